// File: rtl/ring_counter_monitor.sv
// Decoder and legality checker for a right-rotating one-hot ring counter.
// Define RING_MON_AUTORESYNC_EN to let FAULT re-lock on the next valid code without clr_err.
module ring_counter_monitor #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid,
    output logic                     locked,
    output logic                     err,
    output logic [REV_W-1:0]         err_cnt,
    output logic                     rev_tick,
    output logic [REV_W-1:0]         rev_cnt
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {HUNT, TRACK, FAULT} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_code;
    logic             onehot;
    logic [IW-1:0]    pos;
    logic [REV_W-1:0] err_base;
    logic [REV_W-1:0] err_next;

    assign exp_code = {prev[0], prev[WIDTH-1:1]};
    assign onehot   = (q_in != '0) && ((q_in & (q_in - WIDTH'(1))) == '0);

    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_in[i]) pos = IW'(i);
        end
    end

    // A clear in the same cycle as a mismatch restarts the count, so the mismatch leaves it at 1.
    assign err_base = clr_err ? '0 : err_cnt;
    assign err_next = (err_base == '1) ? err_base : err_base + REV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            prev     <= '0;
            idx      <= '0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            rev_tick <= 1'b0;
            rev_cnt  <= '0;
        end else begin
            valid    <= onehot;
            rev_tick <= 1'b0;
            if (onehot) idx <= pos;
            if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
            unique case (state)
                HUNT: begin
                    if (onehot) begin
                        prev   <= q_in;
                        state  <= TRACK;
                        locked <= 1'b1;
                    end
                end
                TRACK: begin
                    if (q_in == exp_code) begin
                        prev <= q_in;
                        // Leaving bit 0 for the top bit closes one full revolution.
                        if (prev[0]) begin
                            rev_tick <= 1'b1;
                            rev_cnt  <= rev_cnt + REV_W'(1);
                        end
                    end else begin
                        state   <= FAULT;
                        locked  <= 1'b0;
                        err     <= 1'b1;
                        err_cnt <= err_next;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        state <= HUNT;
                    end
`ifdef RING_MON_AUTORESYNC_EN
                    else if (onehot) begin
                        prev   <= q_in;
                        state  <= TRACK;
                        locked <= 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule
